// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam int ITER          = WIDTH_DEFAULT;
  localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

endpackage

// File: rtl/sign_fix.sv
// Conditional two's-complement negate: y = neg ? -x : x.
module sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + 1'b1) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// Optional macro DIV_ZERO_EXC_EN: divide-by-zero short-circuits to DONE and pulses div_zero.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   opnd;
  logic [WIDTH-1:0] mplier;
  logic             q_m1;
  logic             sign_a;
  logic             sign_q;

  logic [WIDTH-1:0] abs_a, abs_b, rem_fix, quo_fix;
  logic [WIDTH:0]   booth_sum, div_shift, div_diff, acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             q_next, div_ge;

  sign_fix #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(a[WIDTH-1]), .y(abs_a));
  sign_fix #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(b[WIDTH-1]), .y(abs_b));
  sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.x(acc_next[WIDTH-1:0]), .neg(sign_a), .y(rem_fix));
  sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.x(mplier_next), .neg(sign_q), .y(quo_fix));

  assign busy = (state != IDLE);

  // acc/mplier hold {acc, mplier, q-1} for Booth, and {remainder, dividend/quotient} for division.
  always_comb begin
    booth_sum = acc;
    case ({mplier[0], q_m1})
      2'b01:   booth_sum = acc + opnd;
      2'b10:   booth_sum = acc - opnd;
      default: booth_sum = acc;
    endcase
    div_shift = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    div_ge    = (div_shift >= opnd);
    div_diff  = div_shift - opnd;
    if (state == MULT) begin
      acc_next    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mplier_next = {booth_sum[0], mplier[WIDTH-1:1]};
      q_next      = mplier[0];
    end else begin
      acc_next    = div_ge ? div_diff : div_shift;
      mplier_next = {mplier[WIDTH-2:0], div_ge};
      q_next      = q_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      mplier   <= '0;
      q_m1     <= 1'b0;
      sign_a   <= 1'b0;
      sign_q   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            state  <= MULT;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= {a[WIDTH-1], a};
            mplier <= b;
            q_m1   <= 1'b0;
          end else if (div_start) begin
`ifdef DIV_ZERO_EXC_EN
            if (b == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
`else
            begin
`endif
              state  <= DIV;
              cnt    <= '0;
              acc    <= '0;
              opnd   <= {1'b0, abs_b};
              mplier <= abs_a;
              sign_a <= a[WIDTH-1];
              sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            end
          end
        end
        MULT, DIV: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_m1   <= q_next;
          cnt    <= cnt + 1'b1;
          // Results land only on the final iteration so hi/lo never show partial values.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            if (state == MULT) begin
              hi <= acc_next[WIDTH-1:0];
              lo <= mplier_next;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven self-checking bench for mult_div_unit (honours DIV_ZERO_EXC_EN).
module tb_mult_div_unit;

  logic        clk;
  logic        reset_in;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  typedef struct {
    logic        is_div;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .mult_start(mult_start),
    .div_start (div_start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive a start in cycle 0; returns at the sampling point of cycle 1.
  task automatic startOp(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    mult_start = m;
    div_start  = d;
    a          = av;
    b          = bv;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    logic early_done;
    logic busy_drop;
    early_done = 1'b0;
    busy_drop  = 1'b0;
    startOp(!v.is_div, v.is_div, v.av, v.bv);
    for (int c = 1; c <= 32; c++) begin
      if (c > 1) @(negedge clk);
      if (done) early_done = 1'b1;
      if (!busy) busy_drop = 1'b1;
    end
    checkOutput({name, " early_done"}, {31'b0, early_done}, 32'd0);
    checkOutput({name, " busy_1_32"}, {31'b0, busy_drop}, 32'd0);
    @(negedge clk);
    checkOutput({name, " done_c33"}, {31'b0, done}, 32'd1);
    checkOutput({name, " div_zero_c33"}, {31'b0, div_zero}, 32'd0);
    checkOutput({name, " hi"}, hi, v.exp_hi);
    checkOutput({name, " lo"}, lo, v.exp_lo);
    @(negedge clk);
    checkOutput({name, " done_c34"}, {31'b0, done}, 32'd0);
    checkOutput({name, " busy_c34"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int done_count;
    int done_cycle;
    vec_t v;
    checks     = 0;
    failures   = 0;
    reset_in   = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a          = '0;
    b          = '0;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[4]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6]  = '{1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[7]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[10] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C};

    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    checkOutput("reset div_zero", {31'b0, div_zero}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    reset_in = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in cycle 10 of a multiply discards it entirely.
    startOp(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    checkOutput("midreset busy", {31'b0, busy}, 32'd0);
    checkOutput("midreset hi", hi, 32'd0);
    checkOutput("midreset lo", lo, 32'd0);
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_count++;
      @(negedge clk);
    end
    checkOutput("midreset no_done", done_count, 32'd0);
    v = '{1'b0, 32'd3, 32'd4, 32'd0, 32'd12};
    applyStimulus(v, "after_reset");

    // Both starts together: multiply wins; a div_start while busy is dropped.
    startOp(1'b1, 1'b1, 32'd6, 32'd7);
    done_count = 0;
    done_cycle = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 5) begin
        div_start = 1'b1;
        a = 32'd100;
        b = 32'd3;
      end else if (c == 6) begin
        div_start = 1'b0;
      end
      if (done) begin
        done_count++;
        done_cycle = c;
        checkOutput("both hi", hi, 32'd0);
        checkOutput("both lo", lo, 32'd42);
      end
    end
    checkOutput("both done_count", done_count, 32'd1);
    checkOutput("both done_cycle", done_cycle, 32'd33);
    checkOutput("both idle", {31'b0, busy}, 32'd0);

`ifdef DIV_ZERO_EXC_EN
    startOp(1'b0, 1'b1, 32'd5, 32'd0);
    checkOutput("dz done_c1", {31'b0, done}, 32'd1);
    checkOutput("dz div_zero_c1", {31'b0, div_zero}, 32'd1);
    checkOutput("dz hi_kept", hi, 32'd0);
    checkOutput("dz lo_kept", lo, 32'd42);
    @(negedge clk);
    checkOutput("dz done_c2", {31'b0, done}, 32'd0);
    checkOutput("dz busy_c2", {31'b0, busy}, 32'd0);
`else
    v = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
    applyStimulus(v, "divzero");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
